// File: rtl/mem_pkg.sv
// Shared definitions for the unified memory port arbiter.
//   - RV32I load/store funct3 encodings
//   - arbiter FSM state encoding
//   - transaction owner encoding
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the memory port (purely combinational).
//   Request side (from the request being accepted):
//     is_fetch, we, fun3, off, wdata -> misalign, illegal, wmask, wdata_rep
//   Response side (from the latched request):
//     ld_fun3, ld_off, rdata -> ld_data (lane-extracted, sign/zero extended)
module lsu_align (
    input  logic        is_fetch,
    input  logic        we,
    input  logic [2:0]  fun3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic        misalign,
    output logic        illegal,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_rep,
    input  logic [2:0]  ld_fun3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);
    import mem_pkg::*;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        misalign  = 1'b0;
        illegal   = 1'b0;
        wmask     = 4'b0000;
        wdata_rep = wdata;
        if (is_fetch) begin
            misalign = (off != 2'b00);
        end else begin
            if (we) begin
                illegal = (fun3 > F3_W);
            end else begin
                illegal = (fun3 == 3'b011) || (fun3[2:1] == 2'b11);
            end
            // Access size lives in fun3[1:0] for both signed and unsigned loads.
            case (fun3[1:0])
                2'b01:   misalign = off[0];
                2'b10:   misalign = (off != 2'b00);
                default: misalign = 1'b0;
            endcase
            if (we) begin
                case (fun3)
                    F3_B: begin
                        wmask     = 4'b0001 << off;
                        wdata_rep = {4{wdata[7:0]}};
                    end
                    F3_H: begin
                        wmask     = 4'b0011 << {off[1], 1'b0};
                        wdata_rep = {2{wdata[15:0]}};
                    end
                    F3_W:    wmask = 4'b1111;
                    default: wmask = 4'b0000;
                endcase
            end
        end
    end

    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
        case (ld_fun3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'd0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Fixed priority (data over fetch), one outstanding transaction, req/gnt + rvalid.
//   clk, rst (async, active low)
//   if_req/if_addr            -> if_rdata/if_valid/if_err      fetch side
//   d_req/d_we/d_fun3/d_addr/d_wdata -> d_rdata/d_valid/d_err  load/store side
//   mem_req/mem_we/mem_addr/mem_wmask/mem_wdata, mem_gnt/mem_rvalid/mem_rdata
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_fun3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    import mem_pkg::*;

    state_e           state_q;
    owner_e           owner_q;
    logic [2:0]       fun3_q;
    logic [1:0]       off_q;
    logic [CNT_W-1:0] cnt_q;
    logic             lockout_q;

    // Candidate request as seen in IDLE; data always wins over fetch.
    logic        req_fetch;
    logic        req_we;
    logic [2:0]  req_fun3;
    logic [31:0] req_addr;
    logic        a_misalign;
    logic        a_illegal;
    logic [3:0]  a_wmask;
    logic [31:0] a_wdata;
    logic [31:0] ld_data;
    logic        timeout_hit;

    assign req_fetch = !d_req;
    assign req_we    = d_req && d_we;
    assign req_fun3  = d_req ? d_fun3 : F3_W;
    assign req_addr  = d_req ? d_addr : if_addr;

    // Counter saturates, so >= still fires if a grant lands on the last cycle.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

    lsu_align u_align (
        .is_fetch  (req_fetch),
        .we        (req_we),
        .fun3      (req_fun3),
        .off       (req_addr[1:0]),
        .wdata     (d_wdata),
        .misalign  (a_misalign),
        .illegal   (a_illegal),
        .wmask     (a_wmask),
        .wdata_rep (a_wdata),
        .ld_fun3   (fun3_q),
        .ld_off    (off_q),
        .rdata     (mem_rdata),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IF;
            fun3_q    <= F3_W;
            off_q     <= 2'b00;
            cnt_q     <= '0;
            lockout_q <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wmask <= 4'b0000;
            mem_wdata <= 32'd0;
            if_rdata  <= 32'd0;
            if_valid  <= 1'b0;
            if_err    <= 1'b0;
            d_rdata   <= 32'd0;
            d_valid   <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses raised on entry to DONE.
            if_valid <= 1'b0;
            if_err   <= 1'b0;
            d_valid  <= 1'b0;
            d_err    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    lockout_q <= 1'b0;
                    // Lockout: the previous requester may still hold req this cycle.
                    if (!lockout_q && (d_req || if_req)) begin
                        owner_q <= d_req ? OWN_D : OWN_IF;
                        fun3_q  <= req_fun3;
                        off_q   <= req_addr[1:0];
                        if (a_misalign || (d_req && a_illegal)) begin
                            state_q <= DONE;
                            if (d_req) begin
                                d_valid <= 1'b1;
                                d_err   <= 1'b1;
                            end else begin
                                if_valid <= 1'b1;
                                if_err   <= 1'b1;
                            end
                        end else begin
                            state_q   <= REQ;
                            cnt_q     <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wmask <= a_wmask;
                            mem_wdata <= a_wdata;
                        end
                    end
                end
                REQ: begin
                    if (!(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state_q <= RESP;
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        state_q <= DONE;
                        if (owner_q == OWN_D) begin
                            d_valid <= 1'b1;
                            d_err   <= 1'b1;
                        end else begin
                            if_valid <= 1'b1;
                            if_err   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (!(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
                    if (mem_rvalid) begin
                        state_q <= DONE;
                        if (owner_q == OWN_D) begin
                            d_valid <= 1'b1;
                            // Write acks leave the last load result untouched.
                            if (!mem_we) d_rdata <= ld_data;
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= ld_data;
                        end
                    end else if (timeout_hit) begin
                        state_q <= DONE;
                        if (owner_q == OWN_D) begin
                            d_valid <= 1'b1;
                            d_err   <= 1'b1;
                        end else begin
                            if_valid <= 1'b1;
                            if_err   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    lockout_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_fun3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_valid   (if_valid),
        .if_err     (if_err),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_fun3     (d_fun3),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_valid    (d_valid),
        .d_err      (d_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          issued = 0;
    int          completed = 0;
    int          aborted = 0;
    bit          exp_is_d = 1'b0;
    bit          exp_we = 1'b0;
    bit          exp_access = 1'b0;
    bit          exp_err = 1'b0;
    logic [31:0] exp_addr = 32'd0;
    logic [3:0]  exp_wmask = 4'd0;
    logic [31:0] exp_wdata = 32'd0;
    logic [31:0] exp_rdata = 32'd0;
    logic [31:0] m_if_rdata = 32'd0;
    logic [31:0] m_d_rdata = 32'd0;
    int          req_cycles = 0;
    int          last_req_cycles = 0;

    // Memory responder controls: 0 normal, 1 never grant, 2 grant but never respond
    int          resp_mode = 0;
    int          gnt_delay = 0;
    int          stray_req = 0;
    logic [31:0] mem_word = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned acc_size(input logic [2:0] f3);
        int unsigned s;
        s = int'(f3) % 4;
        if (s == 0) return 1;
        if (s == 1) return 2;
        return 4;
    endfunction

    function automatic bit f_err(input bit is_d, input bit we, input logic [2:0] f3,
                                 input logic [31:0] a);
        int unsigned off;
        off = a % 4;
        if (!is_d) return off != 0;
        if (we && f3 >= 3) return 1'b1;
        if (!we && (f3 == 3 || f3 >= 6)) return 1'b1;
        return (off % acc_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] f_wmask(input bit is_d, input bit we, input logic [2:0] f3,
                                           input logic [31:0] a);
        logic [31:0] m;
        if (!is_d || !we) return 4'd0;
        m = ((32'd1 << acc_size(f3)) - 32'd1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] w);
        if (acc_size(f3) == 1) return (w & 32'hFF) * 32'h01010101;
        if (acc_size(f3) == 2) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
        logic [31:0] v;
        v = word >> (8 * (a % 4));
        if (acc_size(f3) == 1) begin
            v = v & 32'hFF;
            if (f3 < 4 && v >= 128) v = v + 32'hFFFFFF00;
        end else if (acc_size(f3) == 2) begin
            v = v & 32'hFFFF;
            if (f3 < 4 && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input bit is_d, input bit we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] word, input bit tmo);
        bit e;
        e          = f_err(is_d, we, f3, a);
        exp_is_d   = is_d;
        exp_we     = is_d && we;
        exp_access = !e;
        exp_err    = e || tmo;
        exp_addr   = a & 32'hFFFFFFFC;
        exp_wmask  = f_wmask(is_d, we, f3, a);
        exp_wdata  = f_wdata(f3, wd);
        exp_rdata  = is_d ? f_load(f3, a, word) : word;
        mem_word   = word;
        issued++;
    endtask

    task automatic wait_valid(input string name, input int lat);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            seen = if_valid || d_valid;
        end
        check(name, 32'(n), 32'(lat));
    endtask

    // Req is held through the DONE cycle and the following IDLE cycle, then dropped.
    task automatic run_txn(input string name, input bit is_d, input bit we,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] word, input bit tmo,
                           input int lat, input int reqc);
        set_exp(is_d, we, f3, a, wd, word, tmo);
        if (is_d) begin
            d_req   = 1'b1;
            d_we    = we;
            d_fun3  = f3;
            d_addr  = a;
            d_wdata = wd;
        end else begin
            if_req  = 1'b1;
            if_addr = a;
        end
        wait_valid({name, "_latency"}, lat);
        tick();
        d_req  = 1'b0;
        if_req = 1'b0;
        check({name, "_req_cycles"}, 32'(last_req_cycles), 32'(reqc));
        tick();
    endtask

    // Memory responder
    initial begin
        int wait_cnt;
        int stray_done;
        wait_cnt   = 0;
        stray_done = 0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        forever begin
            tick();
            mem_rvalid = 1'b0;
            if (mem_gnt) begin
                mem_gnt = 1'b0;
                if (resp_mode == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_word;
                end
            end else if (mem_req && resp_mode != 1) begin
                if (wait_cnt >= gnt_delay) begin
                    mem_gnt  = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            if (stray_req != stray_done) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEADBEEF;
                stray_done++;
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("reset_outputs_zero",
                      {31'd0, |{if_rdata, if_valid, if_err, d_rdata, d_valid, d_err,
                                mem_req, mem_we, mem_addr, mem_wmask, mem_wdata}}, 32'd0);
                m_if_rdata = 32'd0;
                m_d_rdata  = 32'd0;
                req_cycles = 0;
            end else begin
                if (if_valid || d_valid) begin
                    if (issued == completed + aborted) begin
                        check("unexpected_valid", {30'd0, if_valid, d_valid}, 32'd0);
                    end else begin
                        check("valid_owner", {30'd0, if_valid, d_valid},
                              exp_is_d ? 32'd1 : 32'd2);
                        check("err_flags", {30'd0, if_err, d_err},
                              exp_err ? (exp_is_d ? 32'd1 : 32'd2) : 32'd0);
                        if (!exp_err && !exp_we) begin
                            if (exp_is_d) m_d_rdata = exp_rdata;
                            else m_if_rdata = exp_rdata;
                        end
                        completed++;
                        last_req_cycles = req_cycles;
                        req_cycles = 0;
                    end
                end else begin
                    check("err_without_valid", {30'd0, if_err, d_err}, 32'd0);
                end
                check("if_rdata_hold", if_rdata, m_if_rdata);
                check("d_rdata_hold", d_rdata, m_d_rdata);
                if (mem_req) begin
                    check("mem_req_allowed",
                          {31'd0, (issued != completed + aborted) && exp_access}, 32'd1);
                    check("mem_addr", mem_addr, exp_addr);
                    check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
                    check("mem_wmask", {28'd0, mem_wmask}, {28'd0, exp_wmask});
                    if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
                    req_cycles++;
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        rst     = 1'b0;
        if_req  = 1'b0;
        if_addr = 32'd0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_fun3  = 3'd0;
        d_addr  = 32'd0;
        d_wdata = 32'd0;

        // Pin the model to hand-computed values
        check("pin_lb",   f_load(3'b000, 32'h2, 32'h00F10000), 32'hFFFFFFF1);
        check("pin_lbu",  f_load(3'b100, 32'h2, 32'h00F10000), 32'h000000F1);
        check("pin_lh",   f_load(3'b001, 32'h2, 32'h00F10000), 32'h000000F1);
        check("pin_lh_neg", f_load(3'b001, 32'h0, 32'h00008001), 32'hFFFF8001);
        check("pin_sb_mask", {28'd0, f_wmask(1'b1, 1'b1, 3'b000, 32'h203)}, 32'h8);
        check("pin_sb_data", f_wdata(3'b000, 32'hCDCDEFAB), 32'hABABABAB);
        check("pin_sh_mask", {28'd0, f_wmask(1'b1, 1'b1, 3'b001, 32'h2)}, 32'hC);
        check("pin_lw_mis", {31'd0, f_err(1'b1, 1'b0, 3'b010, 32'h6)}, 32'd1);

        repeat (3) tick();
        rst = 1'b1;
        tick();

        // 1: basic fetch, minimum latency
        run_txn("fetch_100", 1'b0, 1'b0, 3'b010, 32'h100, 32'd0, 32'h00500093, 1'b0, 3, 1);
        check("fetch_100_rdata", if_rdata, 32'h00500093);

        // 2: simultaneous requests, data first, fetch after the lockout cycle
        set_exp(1'b1, 1'b1, 3'b000, 32'h203, 32'hCDCDEFAB, 32'd0, 1'b0);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_fun3  = 3'b000;
        d_addr  = 32'h203;
        d_wdata = 32'hCDCDEFAB;
        if_req  = 1'b1;
        if_addr = 32'h104;
        wait_valid("sim_data_latency", 3);
        check("sim_data_first", {30'd0, if_valid, d_valid}, 32'd1);
        tick();
        d_req = 1'b0;
        set_exp(1'b0, 1'b0, 3'b010, 32'h104, 32'd0, 32'h00000013, 1'b0);
        wait_valid("sim_fetch_latency", 4);
        tick();
        if_req = 1'b0;
        tick();
        check("sim_fetch_rdata", if_rdata, 32'h00000013);

        // 3: load extraction and stores
        run_txn("lb_2",  1'b1, 1'b0, 3'b000, 32'h2, 32'd0, 32'h00F10000, 1'b0, 3, 1);
        check("lb_2_rdata", d_rdata, 32'hFFFFFFF1);
        run_txn("lbu_2", 1'b1, 1'b0, 3'b100, 32'h2, 32'd0, 32'h00F10000, 1'b0, 3, 1);
        check("lbu_2_rdata", d_rdata, 32'h000000F1);
        run_txn("lhu_2", 1'b1, 1'b0, 3'b101, 32'h2, 32'd0, 32'h00F10000, 1'b0, 3, 1);
        run_txn("lh_2",  1'b1, 1'b0, 3'b001, 32'h2, 32'd0, 32'h00F10000, 1'b0, 3, 1);
        run_txn("lh_0",  1'b1, 1'b0, 3'b001, 32'h0, 32'd0, 32'h00008001, 1'b0, 3, 1);
        run_txn("lw_4",  1'b1, 1'b0, 3'b010, 32'h4, 32'd0, 32'h12345678, 1'b0, 3, 1);
        run_txn("sh_2",  1'b1, 1'b1, 3'b001, 32'h2, 32'h0000BEEF, 32'd0, 1'b0, 3, 1);
        run_txn("sw_8",  1'b1, 1'b1, 3'b010, 32'h8, 32'hCAFEF00D, 32'd0, 1'b0, 3, 1);
        check("store_keeps_d_rdata", d_rdata, 32'h12345678);

        // 4: misaligned / illegal requests never reach memory
        run_txn("lw_6_mis",  1'b1, 1'b0, 3'b010, 32'h6, 32'd0, 32'd0, 1'b0, 1, 0);
        run_txn("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h0, 32'd0, 32'd0, 1'b0, 1, 0);
        run_txn("sh_1_mis",  1'b1, 1'b1, 3'b001, 32'h1, 32'h1, 32'd0, 1'b0, 1, 0);
        run_txn("st_f3_011", 1'b1, 1'b1, 3'b011, 32'h0, 32'h1, 32'd0, 1'b0, 1, 0);
        run_txn("fetch_mis", 1'b0, 1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 1'b0, 1, 0);
        check("err_keeps_d_rdata", d_rdata, 32'h12345678);
        run_txn("lbu_3", 1'b1, 1'b0, 3'b100, 32'h3, 32'd0, 32'h80000000, 1'b0, 3, 1);
        check("lbu_3_rdata", d_rdata, 32'h00000080);

        // Delayed grant
        gnt_delay = 1;
        run_txn("fetch_slow", 1'b0, 1'b0, 3'b010, 32'h300, 32'd0, 32'h00100073, 1'b0, 4, 2);
        gnt_delay = 0;

        // 5: grant timeout
        resp_mode = 1;
        run_txn("lw_timeout", 1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 32'd0, 1'b1, 5, 4);
        resp_mode = 0;
        run_txn("lw_after_to", 1'b1, 1'b0, 3'b010, 32'h44, 32'd0, 32'h0BADF00D, 1'b0, 3, 1);
        check("lw_after_to_rdata", d_rdata, 32'h0BADF00D);

        // 6: reset while waiting for the response, then a stray rvalid
        resp_mode = 2;
        set_exp(1'b0, 1'b0, 3'b010, 32'h180, 32'd0, 32'h11111111, 1'b0);
        if_req  = 1'b1;
        if_addr = 32'h180;
        repeat (3) tick();
        rst = 1'b0;
        if_req = 1'b0;
        aborted++;
        repeat (2) tick();
        rst = 1'b1;
        resp_mode = 0;
        stray_req++;
        repeat (4) tick();
        check("stray_no_mem_req", {31'd0, mem_req}, 32'd0);
        run_txn("fetch_after_rst", 1'b0, 1'b0, 3'b010, 32'h200, 32'd0, 32'h00000013, 1'b0, 3, 1);
        check("fetch_after_rst_rdata", if_rdata, 32'h00000013);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port between instruction fetch and the load/store path of the RV32I core. Fixed-priority arbiter and transaction sequencer:
- one outstanding memory transaction at a time;
- req/gnt + rvalid handshake to memory;
- store byte-mask and lane generation, load lane extraction with sign/zero extension;
- misalignment and illegal-fun3 detection, plus a grant/response timeout.

It sits between the core's fetch/load/store control signals and the memory.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in REQ+RESP before abort; 0 disables the timeout.
CNT_W, 8, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held with if_addr stable until if_valid
if_addr  in  32  fetch byte address
if_rdata  out  32  fetched instruction
if_valid  out  1  one-cycle fetch completion pulse
if_err  out  1  qualifies if_valid: fetch misaligned or timed out
d_req  in  1  load/store request (load|store); held stable until d_valid
d_we  in  1  1 = store, 0 = load
d_fun3  in  3  RV32I funct3 of the load/store
d_addr  in  32  data byte address (ALU result)
d_wdata  in  32  store data (rs2)
d_rdata  out  32  extended load result
d_valid  out  1  one-cycle data completion pulse
d_err  out  1  qualifies d_valid: misaligned, illegal fun3, or timeout
mem_req  out  1  memory request
mem_we  out  1  memory write
mem_addr  out  32  word address, bits [1:0] = 0
mem_wmask  out  4  byte write enables
mem_wdata  out  32  lane-replicated write data
mem_gnt  in  1  memory accepts the request this cycle
mem_rvalid  in  1  response valid: read data or write ack
mem_rdata  in  32  read word

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; owner = IF; timeout counter 0.
- Reset is asynchronous at any point, including mid-transaction: return to IDLE, no valid pulse, and mem_rvalid is ignored while in IDLE.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - If d_req is high, data wins; otherwise take if_req if high.
  - Latch owner, word address, mask, wdata, fun3 and addr[1:0].
  - Misaligned or illegal request: go to DONE with err = 1 and no memory access. Misaligned means lh/lhu/sh with addr[0] = 1, or lw/sw/fetch with addr[1:0] != 0. Illegal fun3 means loads 011, 110, 111 and stores >= 011.
  - Otherwise go to REQ.
- REQ:
  - mem_req = 1; mem_we, mem_addr, mem_wmask and mem_wdata are registered and stable.
  - On mem_gnt, go to RESP and drop mem_req the next cycle.
- RESP: on mem_rvalid, capture the extended result and go to DONE.
- DONE:
  - Pulse owner's valid (and err if set) for exactly one cycle, then return to IDLE.
  - The requester's req may still be high in the IDLE cycle following DONE. The arbiter must not re-accept it that cycle: one-cycle IDLE lockout after DONE.
- Minimum latency: req seen at edge N; mem_req high N+1; gnt at N+1; rvalid at N+2; valid at N+3.
- Store mask and data:
  - sb: wmask = 0001 << addr[1:0], wdata = {4{b}}.
  - sh: wmask = 0011 << {addr[1],0}, wdata = {2{h}}.
  - sw: wmask = 1111.
  - Loads and fetches: wmask = 0000, mem_we = 0.
- Load extraction:
  - lb/lbu: byte at addr[1:0], sign/zero extended.
  - lh/lhu: halfword at addr[1], sign/zero extended.
  - lw: whole word.
  - Fetch: whole word to if_rdata.
- Output holding:
  - Read data is held until the next completion of the same owner.
  - Stores complete on mem_rvalid (write ack); d_rdata is unchanged by stores.
- Timeout:
  - Counter clears on entering REQ and increments each cycle in REQ/RESP.
  - On reaching TIMEOUT_CYCLES (nonzero): drop mem_req, go to DONE with err = 1.
  - A late mem_rvalid after a timeout is a memory contract violation and is not handled.
- Simultaneous if_req and d_req: data served first; fetch is served on the next free IDLE. No starvation, because the core holds d_req only once per instruction.

Decomposition:
- Shared package mem_pkg:
  - funct3 constants F3_B/H/W/BU/HU;
  - state encoding (IDLE/REQ/RESP/DONE);
  - owner encoding (OWN_IF/OWN_D).
- Natural sub-module: lsu_align, combinational. Computes misalign/illegal, wmask, wdata replication and load extraction/extension. Instantiated once, with its load-extraction inputs taken from the latched fun3/addr.

Test Plan:
1. Fetch addr 0x100, mem_gnt immediate, rvalid next cycle with 0x00500093 -> if_valid at N+3, if_rdata = 0x00500093, if_err = 0, mem_addr = 0x100, wmask = 0000.
2. Simultaneous if_req (0x104) and d_req sb (addr 0x203, wdata 0xAB) -> data first: mem_we = 1, mem_addr = 0x200, wmask = 1000, wdata = 0xABABABAB. Fetch is issued after d_valid and the lockout cycle.
3. lb addr 0x2 with mem_rdata 0x00F10000 -> d_rdata = 0xFFFFFFF1. lbu at the same address -> 0x000000F1. lhu addr 0x2 -> 0x000000F1. lh addr 0x2 -> 0x000000F1.
4. lw addr 0x6 -> no mem_req; d_valid and d_err one cycle after IDLE accept. Load fun3 = 011 -> d_err = 1.
5. mem_gnt held 0 with TIMEOUT_CYCLES = 4 -> mem_req drops after 4 cycles; d_valid and d_err pulse; FSM back in IDLE.
6. rst asserted while in RESP, then a stray mem_rvalid after release -> all outputs 0, no valid pulse, and the next fetch completes normally.
